// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } mdu_state_e;

  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO      = 5'd0;

  typedef struct packed {
    logic pc_wr;
    logic ifid_wr;
    logic ifid_flush;
    logic bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN   = '{pc_wr: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b0, bubble: 1'b0};
  localparam hz_ctrl_t CTRL_STALL = '{pc_wr: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b0, bubble: 1'b1};
  localparam hz_ctrl_t CTRL_FLUSH = '{pc_wr: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b1, bubble: 1'b1};
  localparam hz_ctrl_t CTRL_RST   = '{pc_wr: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b0, bubble: 1'b1};

  // True when the EX destination feeds a source of the ID instruction; r0 never matches.
  function automatic logic src_match(input logic [4:0] rw, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic uses_rb);
    return (rw != REG_ZERO) && ((rw == ra) || (uses_rb && (rw == rb)));
  endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// Tracks the HI/LO busy window of an in-flight mult/div with a down-counter.
import hazard_pkg::*;

module mdu_scoreboard #(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_i,
  output logic mdu_busy_o
);

  localparam int CW = $clog2(MDU_LAT + 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Once issued the mult is past ID, so the count runs regardless of stalls or flushes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (issue_i && (cnt_q == '0)) begin
          cnt_d   = CW'(MDU_LAT);
          state_d = MDU_WAIT;
        end
      end
      MDU_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mdu_busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / HI-LO hazard controller for the ID stage.
// Optional HAZARD_PERF_EN adds stall_cycles and flush_count performance counters.
import hazard_pkg::*;

module hazard_ctrl #(
  parameter int MDU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_ra,
  input  logic [4:0]  id_rb,
  input  logic        id_uses_rb,
  input  logic        id_reads_HL,
  input  logic        id_mult,
  input  logic [4:0]  ex_rw,
  input  logic        ex_regWr,
  input  logic [1:0]  ex_memtoreg,
  input  logic        ex_branch_taken,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        pc_wr,
  output logic        ifid_wr,
  output logic        ifid_flush,
  output logic        BranchBubble,
  output logic        mdu_busy
);

  logic     load_use, hl_hazard, stall, issue;
  hz_ctrl_t ctrl;

  assign load_use  = (ex_memtoreg == MEMTOREG_LOAD) && ex_regWr &&
                     src_match(ex_rw, id_ra, id_rb, id_uses_rb);
  assign hl_hazard = mdu_busy && (id_reads_HL || id_mult);
  assign stall     = load_use || hl_hazard;

  // A mult only issues when it actually leaves ID: no flush, no stall.
  assign issue = id_mult && !rst && !ex_branch_taken && !stall;

  mdu_scoreboard #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk        (clk),
    .rst        (rst),
    .issue_i    (issue),
    .mdu_busy_o (mdu_busy)
  );

  always_comb begin
    ctrl = CTRL_RUN;
    if (rst)                  ctrl = CTRL_RST;
    else if (ex_branch_taken) ctrl = CTRL_FLUSH;
    else if (stall)           ctrl = CTRL_STALL;
  end

  assign pc_wr        = ctrl.pc_wr;
  assign ifid_wr      = ctrl.ifid_wr;
  assign ifid_flush   = ctrl.ifid_flush;
  assign BranchBubble = ctrl.bubble;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else if (ex_branch_taken) begin
      flush_count_q  <= flush_count_q + 32'd1;
    end else if (stall) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + random check of hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int MDU_LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_ra, id_rb, ex_rw;
  logic       id_uses_rb, id_reads_HL, id_mult, ex_regWr, ex_branch_taken;
  logic [1:0] ex_memtoreg;
  logic       pc_wr, ifid_wr, ifid_flush, BranchBubble, mdu_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_ra           (id_ra),
    .id_rb           (id_rb),
    .id_uses_rb      (id_uses_rb),
    .id_reads_HL     (id_reads_HL),
    .id_mult         (id_mult),
    .ex_rw           (ex_rw),
    .ex_regWr        (ex_regWr),
    .ex_memtoreg     (ex_memtoreg),
    .ex_branch_taken (ex_branch_taken),
`ifdef HAZARD_PERF_EN
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
`endif
    .pc_wr           (pc_wr),
    .ifid_wr         (ifid_wr),
    .ifid_flush      (ifid_flush),
    .BranchBubble    (BranchBubble),
    .mdu_busy        (mdu_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: cycles of HI/LO latency remaining, plus event tallies.
  int          m_busy = 0;
  logic [31:0] m_stalls = 0;
  logic [31:0] m_flushes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive after negedge, check mid-cycle, advance model at posedge.
  task automatic step(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                      input logic urb, input logic hl, input logic mult,
                      input logic [4:0] rw, input logic wr, input logic [1:0] m2r,
                      input logic br);
    logic lu, hz;
    logic [4:0] exp;
    int kind;
    id_ra = ra; id_rb = rb; id_uses_rb = urb; id_reads_HL = hl; id_mult = mult;
    ex_rw = rw; ex_regWr = wr; ex_memtoreg = m2r; ex_branch_taken = br;
    #1;
    lu = (m2r == 2'b01) && wr && (rw != 0) && ((rw == ra) || (urb && (rw == rb)));
    hz = (m_busy > 0) && (hl || mult);
    if (br)            begin kind = 1; exp = {4'b1111, m_busy > 0}; end
    else if (lu || hz) begin kind = 2; exp = {4'b0001, m_busy > 0}; end
    else               begin kind = 3; exp = {4'b1100, m_busy > 0}; end
    chk(tag, {27'd0, pc_wr, ifid_wr, ifid_flush, BranchBubble, mdu_busy}, {27'd0, exp});
    @(posedge clk);
    if (m_busy > 0)              m_busy--;
    else if (kind == 3 && mult)  m_busy = MDU_LAT;
    if (kind == 1) m_flushes++;
    if (kind == 2) m_stalls++;
    @(negedge clk);
  endtask

  task automatic chk_perf(input string tag);
`ifdef HAZARD_PERF_EN
    chk({tag, "_stalls"},  stall_cycles, m_stalls);
    chk({tag, "_flushes"}, flush_count,  m_flushes);
`endif
  endtask

  initial begin
    rst = 1'b1;
    id_ra = 0; id_rb = 0; id_uses_rb = 0; id_reads_HL = 0; id_mult = 0;
    ex_rw = 0; ex_regWr = 0; ex_memtoreg = 0; ex_branch_taken = 0;
    #2;
    chk("reset_outs", {27'd0, pc_wr, ifid_wr, ifid_flush, BranchBubble, mdu_busy}, 32'b00010);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk_perf("reset");

    // Load-use: one bubble, then clears once EX no longer holds the load.
    step("lu_stall",   5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0);
    step("lu_clear",   5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b00, 1'b0);
    step("lu_r0",      5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0);
    step("lu_rb_nouse",5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0);
    step("lu_rb_use",  5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0);
    step("lu_nowr",    5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, 2'b01, 1'b0);
    step("br_wins",    5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b1);

    // Mult issue then mfhi waits MDU_LAT cycles.
    step("mult_issue", 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < MDU_LAT; i++)
      step("mfhi_stall", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    step("mfhi_pass",  5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);

    // Branch flushes during the wait do not disturb the count.
    step("mult_issue2",5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0);
    step("br_in_wait", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1);
    step("br_in_wait", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < MDU_LAT - 1; i++)
      step("mfhi_tail", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);

    // Flushed mult must not issue.
    step("mult_flushed",5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 1'b1);
    step("mfhi_noissue",5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    chk_perf("directed");

    // Reset mid-wait clears busy without waiting for a clock edge.
    step("mult_issue3",5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00, 1'b0);
    step("idle_wait",  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    #2 rst = 1'b1;
    #1 chk("async_rst", {27'd0, pc_wr, ifid_wr, ifid_flush, BranchBubble, mdu_busy}, 32'b00010);
    m_busy = 0; m_stalls = 0; m_flushes = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk_perf("after_rst");
    step("mfhi_after_rst", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);

    // Random traffic on a narrow register range to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
           5'($urandom_range(0, 3)), 1'($urandom), 2'($urandom),
           ($urandom_range(0, 7) == 0));
    end
    chk_perf("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
